// File: rtl/piano_pkg.sv
// Shared types, constants and the note half-period table for uart_poly_piano.
package piano_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

   localparam int         KEY_W       = 5;
   localparam int         NUM_KEYS    = 13;
   localparam logic [7:0] CMD_ALL_OFF = 8'hFF;

   // Half period in clk cycles for keys 0..12 (C4..C5), rounded to nearest.
   // Frequencies are in mHz and reproduce the legacy piano table.
   function automatic int unsigned HALF_PERIOD(input longint unsigned clk_hz,
                                               input int unsigned key);
      longint unsigned f_mhz;
      case (key)
         0:       f_mhz = 64'd261630;
         1:       f_mhz = 64'd277180;
         2:       f_mhz = 64'd293660;
         3:       f_mhz = 64'd311130;
         4:       f_mhz = 64'd329630;
         5:       f_mhz = 64'd349230;
         6:       f_mhz = 64'd369990;
         7:       f_mhz = 64'd392000;
         8:       f_mhz = 64'd415300;
         9:       f_mhz = 64'd440000;
         10:      f_mhz = 64'd466160;
         11:      f_mhz = 64'd493880;
         default: f_mhz = 64'd523251;
      endcase
      return 32'((clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz));
   endfunction

endpackage

// File: rtl/uart_rx_os.sv
// Oversampled 8N1 UART receiver driven by a clock-enable tick, with framing-error detection.
module uart_rx_os
   import piano_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       done,
   output logic       frame_err
);
   localparam int DIV   = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);

   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic             rx_meta, rx_sync, rx_prev;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   rx_state_t        state;
   logic [OS_W-1:0]  os_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;

   // Sync resets to idle-high so leaving reset never looks like a start edge.
   // NOTE: every register in this design is written with <= so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == DIV_W'(DIV - 1)) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
         tick    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         os_cnt    <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data      <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: if (rx_prev && !rx_sync) begin
               state  <= START;
               os_cnt <= '0;
            end
            START: if (tick) begin
               if (os_cnt == OS_HALF) begin
                  os_cnt  <= '0;
                  bit_cnt <= '0;
                  state   <= rx_sync ? IDLE : DATA;
               end else begin
                  os_cnt <= os_cnt + OS_W'(1);
               end
            end
            DATA: if (tick) begin
               if (os_cnt == OS_LAST) begin
                  os_cnt  <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  os_cnt <= os_cnt + OS_W'(1);
               end
            end
            STOP: if (tick) begin
               if (os_cnt == OS_LAST) begin
                  os_cnt <= '0;
                  if (rx_sync) begin
                     done  <= 1'b1;
                     data  <= shreg;
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  os_cnt <= os_cnt + OS_W'(1);
               end
            end
            WAIT_HIGH: if (rx_sync) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_poly_piano.sv
// Serial-controlled polyphonic square-wave piano with a 1-bit sigma-delta mixer.
module uart_poly_piano
   import piano_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int VOICES     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [7:0]        LED,
   output logic              done,
   output logic              frame_err,
   output logic [VOICES-1:0] voice_busy,
   output logic              audioOut
);
   localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int CNT_W = $clog2(HALF_PERIOD(64'(CLK_HZ), 0));

   logic [CNT_W-1:0] half_m1 [2**KEY_W];
   logic [KEY_W-1:0] key [VOICES];
   logic [CNT_W-1:0] cnt [VOICES];
   logic [VOICES-1:0] busy, sq;
   logic [PTR_W-1:0]  ptr, free_idx, load_idx;
   logic              free_any, hit_any;
   logic [KEY_W-1:0]  cmd_key;
   logic [3:0]        s, acc, sum;

   uart_rx_os #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (LED),
      .done      (done),
      .frame_err (frame_err)
   );

   // Unmapped keys never reach a voice, so their entries are don't-care.
   for (genvar k = 0; k < 2**KEY_W; k++) begin : g_half
      localparam int unsigned H = (k < NUM_KEYS) ? HALF_PERIOD(64'(CLK_HZ), k) : 1;
      assign half_m1[k] = CNT_W'(H - 1);
   end

   assign cmd_key    = LED[KEY_W-1:0];
   assign voice_busy = busy;

   // Descending scan so the lowest-index free voice wins.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      hit_any  = 1'b0;
      for (int v = VOICES - 1; v >= 0; v--) begin
         if (!busy[v]) begin
            free_any = 1'b1;
            free_idx = PTR_W'(v);
         end
         if (busy[v] && key[v] == cmd_key) hit_any = 1'b1;
      end
      load_idx = free_any ? free_idx : ptr;
   end

   // NOTE: the voice arrays are only a few flops each, so they are reset like any other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < VOICES; v++) begin
            key[v] <= '0;
            cnt[v] <= '0;
         end
         busy <= '0;
         sq   <= '0;
         ptr  <= '0;
      end else begin
         for (int v = 0; v < VOICES; v++) begin
            if (busy[v]) begin
               if (cnt[v] == half_m1[key[v]]) begin
                  cnt[v] <= '0;
                  sq[v]  <= ~sq[v];
               end else begin
                  cnt[v] <= cnt[v] + CNT_W'(1);
               end
            end
         end
         if (done) begin
            if (LED == CMD_ALL_OFF) begin
               busy <= '0;
               sq   <= '0;
            end else if (cmd_key < KEY_W'(NUM_KEYS)) begin
               if (!LED[7]) begin
                  if (!hit_any) begin
                     key[load_idx]  <= cmd_key;
                     cnt[load_idx]  <= '0;
                     busy[load_idx] <= 1'b1;
                     sq[load_idx]   <= 1'b0;
                     if (!free_any)
                        ptr <= (ptr == PTR_W'(VOICES - 1)) ? '0 : ptr + PTR_W'(1);
                  end
               end else begin
                  for (int v = 0; v < VOICES; v++) begin
                     if (busy[v] && key[v] == cmd_key) begin
                        busy[v] <= 1'b0;
                        sq[v]   <= 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      s = '0;
      for (int v = 0; v < VOICES; v++) s = s + {3'b000, busy[v] & sq[v]};
      sum = acc + s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         audioOut <= 1'b0;
      end else if (sum >= 4'(VOICES)) begin
         acc      <= sum - 4'(VOICES);
         audioOut <= 1'b1;
      end else begin
         acc      <= sum;
         audioOut <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_poly_piano.sv
// Directed bench for uart_poly_piano, scaled to a 100 kHz clock so whole frames stay short.
module tb_uart_poly_piano;
   localparam int CLK_HZ    = 100_000;
   localparam int BAUD      = 6250;
   localparam int OS        = 8;
   localparam int VOICES    = 4;
   localparam int BIT       = 16;   // DIV = 100000/(6250*8) = 2 cycles, times 8 ticks
   localparam int A4_PERIOD = 228;  // half = round(100000/880) = 114

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx  = 1'b1;
   logic [7:0]        LED;
   logic              done, frame_err, audioOut;
   logic [VOICES-1:0] voice_busy;

   int vectors = 0, miscompares = 0;
   int done_cnt = 0, ferr_cnt = 0, both_cnt = 0, cycle = 0;
   logic [7:0] led_at_done = 8'h00;

   always #5 clk = ~clk;

   uart_poly_piano #(
      .CLK_HZ (CLK_HZ), .BAUD (BAUD), .OVERSAMPLE (OS), .VOICES (VOICES)
   ) dut (
      .clk (clk), .rst (rst), .rx (rx), .LED (LED), .done (done),
      .frame_err (frame_err), .voice_busy (voice_busy), .audioOut (audioOut)
   );

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         led_at_done = LED;
      end
      if (frame_err) ferr_cnt++;
      if (done && frame_err) both_cnt++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT + 4) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] b, input logic [3:0] exp_busy, input string tag);
      int d0;
      d0 = done_cnt;
      send_byte(b, 1'b1);
      check({tag, " done"}, done_cnt - d0, 1);
      check({tag, " LED"}, 32'(LED), 32'(b));
      check({tag, " busy"}, 32'(voice_busy), 32'(exp_busy));
   endtask

   task automatic wait_rise(output logic ok);
      logic prev;
      ok   = 1'b0;
      prev = dut.sq[0];
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (dut.sq[0] && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = dut.sq[0];
      end
   endtask

   initial begin
      int d0, f0, ones, t0;
      logic ok_a, ok_b;

      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset LED", 32'(LED), 0);
      check("reset done", 32'(done), 0);
      check("reset frame_err", 32'(frame_err), 0);
      check("reset busy", 32'(voice_busy), 0);
      check("reset audio", 32'(audioOut), 0);

      // A4 note-on: one voice, exact period, density 1/4 while high
      send_cmd(8'h09, 4'b0001, "on A4");
      check("LED at done", 32'(led_at_done), 32'h09);
      wait_rise(ok_a);
      t0 = cycle;
      wait_rise(ok_b);
      check("sq0 rise seen", 32'({ok_a, ok_b}), 32'b11);
      check("sq0 period", cycle - t0, A4_PERIOD);
      ones = 0;
      repeat (8 * A4_PERIOD) begin
         @(negedge clk);
         ones += int'(audioOut);
      end
      check("audio density", ones, 228);

      // Framing error, then line held low for 20 bit times
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_byte(8'h55, 1'b0);
      check("ferr pulse", ferr_cnt - f0, 1);
      check("ferr no done", done_cnt - d0, 0);
      check("ferr LED kept", 32'(LED), 32'h09);
      repeat (20 * BIT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check("ferr no repeat", ferr_cnt - f0, 1);
      check("ferr still no done", done_cnt - d0, 0);
      send_cmd(8'h89, 4'b0000, "off A4");

      // Allocation and stealing
      send_cmd(8'h00, 4'b0001, "on k0");
      send_cmd(8'h02, 4'b0011, "on k2");
      send_cmd(8'h04, 4'b0111, "on k4");
      send_cmd(8'h05, 4'b1111, "on k5");
      send_cmd(8'h07, 4'b1111, "steal k7");
      send_cmd(8'h02, 4'b1111, "repeat k2");
      send_cmd(8'h80, 4'b1111, "off stolen k0");
      send_cmd(8'h87, 4'b1110, "off k7");
      send_cmd(8'h0C, 4'b1111, "on k12 free v0");
      send_cmd(8'h01, 4'b1111, "steal v1 k1");
      send_cmd(8'h82, 4'b1111, "off inactive k2");
      send_cmd(8'h84, 4'b1011, "off k4");
      send_cmd(8'hE5, 4'b0011, "off k5 b65 set");
      send_cmd(8'hFF, 4'b0000, "all off");
      ones = 0;
      repeat (300) begin
         @(negedge clk);
         ones += int'(audioOut);
      end
      check("silent after all off", ones, 0);
      send_cmd(8'h1F, 4'b0000, "unmapped k31");

      // Short low glitch is rejected
      d0 = done_cnt;
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      check("glitch no done", done_cnt - d0, 0);
      check("glitch no ferr", ferr_cnt - f0, 0);
      send_cmd(8'h09, 4'b0001, "after glitch");

      // Reset in the middle of the data bits, released while the line is high
      d0 = done_cnt;
      f0 = ferr_cnt;
      fork
         send_byte(8'hF0, 1'b1);
         begin
            repeat (40) @(negedge clk);
            rst = 1'b1;
            repeat (60) @(negedge clk);
            rst = 1'b0;
         end
      join
      check("midrst no done", done_cnt - d0, 0);
      check("midrst no ferr", ferr_cnt - f0, 0);
      check("midrst LED", 32'(LED), 0);
      check("midrst busy", 32'(voice_busy), 0);
      check("midrst audio", 32'(audioOut), 0);
      send_cmd(8'h04, 4'b0001, "post reset");

      check("done and frame_err overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
